// File: rtl/gpio_checkpoint_monitor.sv
// Watches a GPIO field for an ordered list of expected values and reports
// pass/fail/timeout. Expected values are queued in a small FIFO ahead of a run.
module gpio_checkpoint_monitor #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int STABLE    = 2,
  parameter int TIMEOUT   = 20000,
  parameter int HB_PERIOD = 1000,
  localparam int IW       = $clog2(DEPTH + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  output logic             exp_ready,
  input  logic             obs_en,
  input  logic [WIDTH-1:0] obs_data,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             chk_hit,
  output logic [IW-1:0]    chk_idx,
  output logic             heartbeat,
  output logic [WIDTH-1:0] fail_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;
  state_t state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [IW-1:0]    count;
  logic [SW-1:0]    stab_cnt, stab_nxt;
  logic [WIDTH-1:0] sample, prev_match;
  logic [TW-1:0]    tmo_cnt, tmo_nxt;
  logic [HW-1:0]    hb_cnt;
  logic             push, same, settled, head_hit, bad, tmo_reach, flush, last_hit;

  assign exp_ready = (count != IW'(DEPTH));
  assign busy      = (state == S_RUN);
  assign pass      = (state == S_PASS);
  assign fail      = (state == S_FAIL);
  assign timeout   = (state == S_TMO);

  always_comb begin
    push     = exp_valid && exp_ready;
    same     = (obs_data == sample);
    stab_nxt = stab_cnt;
    if (!obs_en)                       stab_nxt = '0;
    else if (!same)                    stab_nxt = SW'(1);
    else if (stab_cnt != SW'(STABLE))  stab_nxt = stab_cnt + SW'(1);
    // Fire only on the edge the count first reaches STABLE, so a held value
    // is judged once; a fresh value with STABLE=1 settles immediately.
    settled   = busy && obs_en && (stab_nxt == SW'(STABLE)) &&
                (!same || stab_cnt != SW'(STABLE));
    head_hit  = settled && (obs_data == mem[rd_ptr]);
    bad       = settled && !head_hit && (obs_data != prev_match);
    tmo_nxt   = tmo_cnt + TW'(1);
    tmo_reach = busy && (tmo_nxt == TW'(TIMEOUT));
    flush     = bad || (tmo_reach && !head_hit);
    last_hit  = head_hit && (count == IW'(1));
  end

  always_ff @(posedge wb_clk_i)
    if (push) mem[wr_ptr] <= exp_data;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stab_cnt   <= '0;
      sample     <= '0;
      prev_match <= '0;
      tmo_cnt    <= '0;
      hb_cnt     <= '0;
      chk_hit    <= 1'b0;
      chk_idx    <= '0;
      heartbeat  <= 1'b0;
      fail_data  <= '0;
    end else begin
      chk_hit   <= 1'b0;
      heartbeat <= 1'b0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)     wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        if (head_hit) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        case ({push, head_hit})
          2'b10:   count <= count + IW'(1);
          2'b01:   count <= count - IW'(1);
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          hb_cnt <= '0;
          if (start && count != '0) begin
            state    <= S_RUN;
            chk_idx  <= '0;
            tmo_cnt  <= '0;
            stab_cnt <= '0;
          end
        end
        S_RUN: begin
          stab_cnt <= stab_nxt;
          if (obs_en && !same) sample <= obs_data;
          if (hb_cnt == HW'(HB_PERIOD - 1)) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b1;
          end else begin
            hb_cnt <= hb_cnt + HW'(1);
          end
          tmo_cnt <= tmo_nxt;
          // A hit on the timeout edge wins and restarts the window.
          if (head_hit) begin
            chk_hit    <= 1'b1;
            chk_idx    <= chk_idx + IW'(1);
            tmo_cnt    <= '0;
            prev_match <= obs_data;
            if (last_hit) state <= S_PASS;
          end else if (bad) begin
            state     <= S_FAIL;
            fail_data <= obs_data;
          end else if (tmo_reach) begin
            state <= S_TMO;
          end
          if (last_hit || flush) hb_cnt <= '0;
        end
        default: begin
          hb_cnt <= '0;
          if (start) begin
            state      <= S_IDLE;
            fail_data  <= '0;
            chk_idx    <= '0;
            prev_match <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_checkpoint_monitor.sv
// Scoreboard bench: stimulus queues expected events, a monitor matches them
// against chk_hit pulses, terminal-state entries and explicit snapshots.
module tb_gpio_checkpoint_monitor;
  localparam int K_HIT = 0, K_END = 1, K_SNAP = 2;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, exp_valid = 1'b0, obs_en = 1'b0;
  logic [15:0] exp_data = '0, obs_data = '0;
  logic        exp_ready, busy, pass, fail, timeout, chk_hit, heartbeat;
  logic [2:0]  chk_idx;
  logic [15:0] fail_data;

  always #5 clk = ~clk;

  gpio_checkpoint_monitor #(.WIDTH(16), .DEPTH(4), .STABLE(2), .TIMEOUT(50), .HB_PERIOD(10)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .obs_en(obs_en), .obs_data(obs_data),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .chk_hit(chk_hit), .chk_idx(chk_idx), .heartbeat(heartbeat), .fail_data(fail_data)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [9:0]  flags;  // {busy,pass,fail,timeout,exp_ready,chk_hit,heartbeat,chk_idx[2:0]}
    logic [15:0] fdata;
    int          run;    // RUN cycles observed, -1 = don't care
    int          hb;     // heartbeat pulses observed, -1 = don't care
  } exp_t;

  exp_t q[$];
  int   probe_seq = 0;
  bit   done = 1'b0;
  int   total = 0, passed = 0;

  function automatic logic [9:0] fl(bit b, bit p, bit f, bit t, bit r, bit h, bit hb, logic [2:0] idx);
    return {b, p, f, t, r, h, hb, idx};
  endfunction

  task automatic expect_ev(input string n, input int k, input logic [9:0] f,
                           input logic [15:0] fd, input int run, input int hb);
    exp_t e;
    e.name = n; e.kind = k; e.flags = f; e.fdata = fd; e.run = run; e.hb = hb;
    q.push_back(e);
  endtask

  task automatic snap(input string n, input logic [9:0] f, input logic [15:0] fd);
    expect_ev(n, K_SNAP, f, fd, -1, -1);
    probe_seq++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    exp_valid = 1'b1; exp_data = v; tick(); exp_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic drive(input logic [15:0] v, input int n);
    obs_en = 1'b1; obs_data = v;
    repeat (n) tick();
  endtask

  task automatic wait_term(input int bound);
    for (int i = 0; i < bound && !(pass || fail || timeout); i++) tick();
  endtask

  task automatic take(input int kind, input int run, input int hb);
    exp_t e;
    bit ok;
    logic [9:0] act;
    act = {busy, pass, fail, timeout, exp_ready, chk_hit, heartbeat, chk_idx};
    total++;
    if (q.size() == 0 || q[0].kind != kind) begin
      $display("FAIL unexpected_event kind=%0d: got flags=%b fail_data=%h, pending=%0d", kind, act, fail_data, q.size());
      return;
    end
    e = q.pop_front();
    case (kind)
      K_HIT:   ok = (chk_idx == e.flags[2:0]);
      K_END:   ok = ({pass, fail, timeout} == e.flags[8:6]) && (chk_idx == e.flags[2:0]) &&
                    (fail_data == e.fdata) && (e.run < 0 || e.run == run) && (e.hb < 0 || e.hb == hb);
      default: ok = (act == e.flags) && (fail_data == e.fdata);
    endcase
    if (ok) passed++;
    else $display("FAIL %s: got flags=%b fail_data=%h run=%0d hb=%0d, want flags=%b fail_data=%h run=%0d hb=%0d",
                  e.name, act, fail_data, run, hb, e.flags, e.fdata, e.run, e.hb);
  endtask

  // Monitor
  initial begin
    int seen, run_cnt, hb_cnt;
    bit pbusy, pterm;
    exp_t e;
    seen = 0; run_cnt = 0; hb_cnt = 0; pbusy = 1'b0; pterm = 1'b0;
    while (!done) begin
      @(negedge clk); #1;
      if (busy && !pbusy) begin run_cnt = 0; hb_cnt = 0; end
      if (busy) run_cnt++;
      if (heartbeat) hb_cnt++;
      pbusy = busy;
      if (chk_hit) take(K_HIT, run_cnt, hb_cnt);
      if ((pass || fail || timeout) && !pterm) take(K_END, run_cnt, hb_cnt);
      pterm = pass || fail || timeout;
      while (seen != probe_seq) begin seen++; take(K_SNAP, run_cnt, hb_cnt); end
    end
    while (q.size() != 0) begin
      e = q.pop_front();
      total++;
      $display("FAIL %s: expected event never observed (got nothing, want kind %0d)", e.name, e.kind);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Stimulus
  initial begin
    tick(); tick();
    snap("reset", fl(0,0,0,0,1,0,0,0), 16'h0);
    tick(); rst = 1'b0;

    // two checkpoints in order
    push(16'h00A1); push(16'h00A2);
    snap("t1_loaded", fl(0,0,0,0,1,0,0,0), 16'h0);
    expect_ev("t1_hit1", K_HIT, fl(0,0,0,0,0,0,0,1), 16'h0, -1, -1);
    expect_ev("t1_hit2", K_HIT, fl(0,0,0,0,0,0,0,2), 16'h0, -1, -1);
    expect_ev("t1_pass", K_END, fl(0,1,0,0,0,0,0,2), 16'h0, 4, 0);
    do_start(); drive(16'h00A1, 2); drive(16'h00A2, 2);
    obs_en = 1'b0; tick();
    snap("t1_pass_hold", fl(0,1,0,0,1,0,0,2), 16'h0);
    do_start();
    snap("t1_idle", fl(0,0,0,0,1,0,0,0), 16'h0);

    // glitch and a settled zero are tolerated
    push(16'h00A1);
    expect_ev("t2_hit", K_HIT, fl(0,0,0,0,0,0,0,1), 16'h0, -1, -1);
    expect_ev("t2_pass", K_END, fl(0,1,0,0,0,0,0,1), 16'h0, 8, -1);
    do_start(); drive(16'h00FF, 1); drive(16'h0000, 5); drive(16'h00A1, 2);
    obs_en = 1'b0; tick();
    snap("t2_pass_hold", fl(0,1,0,0,1,0,0,1), 16'h0);
    do_start();

    // wrong value fails and flushes a full FIFO
    push(16'h00A1); push(16'h00A2); push(16'h00A3); push(16'h00A4);
    snap("t3_full", fl(0,0,0,0,0,0,0,0), 16'h0);
    expect_ev("t3_fail", K_END, fl(0,0,1,0,0,0,0,0), 16'h00B7, 2, -1);
    do_start(); drive(16'h00B7, 2);
    obs_en = 1'b0; tick();
    snap("t3_fail_flushed", fl(0,0,1,0,1,0,0,0), 16'h00B7);
    do_start();
    snap("t3_idle", fl(0,0,0,0,1,0,0,0), 16'h0);
    do_start();
    snap("t3_start_empty_ignored", fl(0,0,0,0,1,0,0,0), 16'h0);

    // timeout with heartbeats
    push(16'h00A1);
    expect_ev("t4_timeout", K_END, fl(0,0,0,1,0,0,0,0), 16'h0, 50, 5);
    do_start(); obs_en = 1'b1; obs_data = 16'h0000;
    wait_term(70); tick();
    snap("t4_tmo_hold", fl(0,0,0,1,1,0,0,0), 16'h0);
    obs_en = 1'b0; do_start();

    // hit on the timeout edge wins and restarts the window
    push(16'h00A1); push(16'h00A2);
    expect_ev("t5_hit_on_tmo_edge", K_HIT, fl(0,0,0,0,0,0,0,1), 16'h0, -1, -1);
    do_start(); obs_en = 1'b1; obs_data = 16'h0000;
    repeat (48) tick();
    drive(16'h00A1, 2); tick();
    snap("t5_still_running", fl(1,0,0,0,1,0,0,1), 16'h0);
    expect_ev("t5_timeout", K_END, fl(0,0,0,1,0,0,0,1), 16'h0, 100, 10);
    wait_term(70);
    obs_en = 1'b0; do_start();

    // fifth push into a full FIFO is dropped
    exp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_data = 16'h00B1 + 16'(i); tick();
      if (i == 3) snap("t6_full_after4", fl(0,0,0,0,0,0,0,0), 16'h0);
    end
    exp_valid = 1'b0;
    snap("t6_full_after5", fl(0,0,0,0,0,0,0,0), 16'h0);
    for (int i = 1; i <= 4; i++)
      expect_ev($sformatf("t6_hit%0d", i), K_HIT, fl(0,0,0,0,0,0,0,3'(i)), 16'h0, -1, -1);
    expect_ev("t6_pass", K_END, fl(0,1,0,0,0,0,0,4), 16'h0, 8, -1);
    do_start();
    for (int i = 0; i < 4; i++) drive(16'h00B1 + 16'(i), 2);
    obs_en = 1'b0; tick();
    snap("t6_pass_hold", fl(0,1,0,0,1,0,0,4), 16'h0);
    do_start();

    // reset mid-run
    push(16'h00C1); push(16'h00C2); push(16'h00C3);
    expect_ev("t7_hit", K_HIT, fl(0,0,0,0,0,0,0,1), 16'h0, -1, -1);
    do_start(); drive(16'h00C1, 2); drive(16'h00C2, 1);
    rst = 1'b1; tick();
    snap("t7_rst_midrun", fl(0,0,0,0,1,0,0,0), 16'h0);
    rst = 1'b0; obs_en = 1'b0;
    do_start();
    snap("t7_fifo_empty_after_rst", fl(0,0,0,0,1,0,0,0), 16'h0);
    tick(); tick();
    done = 1'b1;
  end
endmodule
